// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: widths, reset PC and the bubble encoding.
package mips_pkg;
    localparam int ADDR_W = 32;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;
    // sll $0,$0,0
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = '0;

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
interface if_stage_if;
    import mips_pkg::*;

    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               jump;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc_plus4;
    logic               ifid_valid;
    logic               misalign_err;

    // Fetch-stage side. Plain level signals, no handshake: inputs are sampled
    // on every rising clk edge, imem_instr must be valid for imem_addr in the
    // same cycle.
    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, imem_instr,
        output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, misalign_err
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, imem_instr,
        input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, misalign_err
    );
endinterface

// File: rtl/if_stage_pc_next_sel.sv
// Combinational next-PC and IF/ID load/flush selection.
// Priority: branch_taken, jump, stall, sequential.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic              load_ifid,
    output logic              flush_ifid,
    output logic              redirect_misaligned
);
    always_comb begin
        pc_next             = pc + ADDR_W'(4);
        load_ifid           = 1'b1;
        flush_ifid          = 1'b0;
        redirect_misaligned = 1'b0;
        if (branch_taken) begin
            pc_next             = branch_target;
            load_ifid           = 1'b0;
            flush_ifid          = 1'b1;
            redirect_misaligned = is_misaligned(branch_target);
        end else if (jump) begin
            // The instruction fetched alongside a jump is its wrong-path successor.
            pc_next             = jump_target;
            load_ifid           = 1'b0;
            flush_ifid          = 1'b1;
            redirect_misaligned = is_misaligned(jump_target);
        end else if (stall) begin
            pc_next   = pc;
            load_ifid = 1'b0;
        end
    end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter plus IF/ID pipeline register.
// Redirects insert a bubble; misalign_err is sticky until reset.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    if_stage_if.master bus
);
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;
    logic               valid_q, valid_d;
    logic               misalign_q, misalign_d;

    logic [ADDR_W-1:0]  pc_next;
    logic               load_ifid;
    logic               flush_ifid;
    logic               redirect_misaligned;

    pc_next_sel u_pc_next_sel (
        .pc                  (pc_q),
        .stall               (bus.stall),
        .branch_taken        (bus.branch_taken),
        .branch_target       (bus.branch_target),
        .jump                (bus.jump),
        .jump_target         (bus.jump_target),
        .pc_next             (pc_next),
        .load_ifid           (load_ifid),
        .flush_ifid          (flush_ifid),
        .redirect_misaligned (redirect_misaligned)
    );

    always_comb begin
        pc_d       = pc_next;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        misalign_d = misalign_q | redirect_misaligned;
        if (flush_ifid) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (load_ifid) begin
            // load_ifid only on sequential fetch, where pc_next is pc+4.
            instr_d    = bus.imem_instr;
            pc_plus4_d = pc_next;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.ifid_instr    = instr_q;
    assign bus.ifid_pc_plus4 = pc_plus4_q;
    assign bus.ifid_valid    = valid_q;
    assign bus.misalign_err  = misalign_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, redirects, wrap,
// sticky misalign flag and asynchronous reset.
module tb_if_stage;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: three program words, a recognisable pattern elsewhere.
    function automatic logic [31:0] imem_model(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h2002_0007;
            32'h0000_0008: return 32'h0022_1820;
            default:       return {a[15:0], 16'h1234};
        endcase
    endfunction

    assign bus.imem_instr = imem_model(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, "_instr"}, bus.ifid_instr, instr);
        check({tag, "_pc4"}, bus.ifid_pc_plus4, pc4);
        check({tag, "_valid"}, 32'(bus.ifid_valid), 32'(valid));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;

        #12;
        check("rst_addr", bus.imem_addr, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check("rst_misalign", 32'(bus.misalign_err), 32'h0);
        rst_n = 1'b1;

        // Sequential fetch 0 -> 4 -> 8
        step();
        check("seq1_addr", bus.imem_addr, 32'h4);
        check_ifid("seq1", 32'h2001_0005, 32'h4, 1'b1);
        step();
        check("seq2_addr", bus.imem_addr, 32'h8);
        check_ifid("seq2", 32'h2002_0007, 32'h8, 1'b1);

        // Stall two cycles at pc=8
        bus.stall = 1'b1;
        step();
        check("stall1_addr", bus.imem_addr, 32'h8);
        check_ifid("stall1", 32'h2002_0007, 32'h8, 1'b1);
        step();
        check("stall2_addr", bus.imem_addr, 32'h8);
        check_ifid("stall2", 32'h2002_0007, 32'h8, 1'b1);
        bus.stall = 1'b0;
        step();
        check("rel_addr", bus.imem_addr, 32'hC);
        check_ifid("rel", 32'h0022_1820, 32'hC, 1'b1);
        step();
        check("seq3_addr", bus.imem_addr, 32'h10);
        check_ifid("seq3", 32'h000C_1234, 32'h10, 1'b1);

        // Taken branch at pc=0x10
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        step();
        bus.branch_taken = 1'b0;
        check("br_addr", bus.imem_addr, 32'h40);
        check("br_instr", bus.ifid_instr, 32'h0);
        check("br_valid", 32'(bus.ifid_valid), 32'h0);
        step();
        check("br_next_addr", bus.imem_addr, 32'h44);
        check_ifid("br_next", 32'h0040_1234, 32'h44, 1'b1);

        // Branch beats simultaneous jump and stall
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h80;
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h100;
        bus.stall         = 1'b1;
        step();
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
        check("prio_addr", bus.imem_addr, 32'h80);
        check("prio_instr", bus.ifid_instr, 32'h0);
        check("prio_valid", 32'(bus.ifid_valid), 32'h0);
        check("prio_misalign", 32'(bus.misalign_err), 32'h0);

        // Jump overrides stall; misaligned target sets the sticky flag
        bus.jump        = 1'b1;
        bus.jump_target = 32'h102;
        step();
        bus.jump  = 1'b0;
        bus.stall = 1'b0;
        check("jmis_addr", bus.imem_addr, 32'h102);
        check("jmis_valid", 32'(bus.ifid_valid), 32'h0);
        check("jmis_err", 32'(bus.misalign_err), 32'h1);
        step();
        check("jmis_seq_addr", bus.imem_addr, 32'h106);
        check_ifid("jmis_seq", 32'h0102_1234, 32'h106, 1'b1);
        check("jmis_seq_err", 32'(bus.misalign_err), 32'h1);

        // Wrap-around from the top of the address space
        bus.jump        = 1'b1;
        bus.jump_target = 32'hFFFF_FFFC;
        step();
        bus.jump = 1'b0;
        check("wrap_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr", bus.imem_addr, 32'h0);
        check_ifid("wrap", 32'hFFFC_1234, 32'h0, 1'b1);
        check("wrap_err", 32'(bus.misalign_err), 32'h1);

        // Aligned jump to 0x20, fetch to 0x24, then async reset mid-cycle
        bus.jump        = 1'b1;
        bus.jump_target = 32'h20;
        step();
        bus.jump = 1'b0;
        check("j20_err", 32'(bus.misalign_err), 32'h1);
        step();
        check("pre_rst_addr", bus.imem_addr, 32'h24);
        check("pre_rst_valid", 32'(bus.ifid_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr", bus.imem_addr, 32'h0);
        check_ifid("arst", 32'h0, 32'h0, 1'b0);
        check("arst_err", 32'(bus.misalign_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter and drives the address port of instruction_mem. It captures the returned instruction into the IF/ID pipeline register. It also handles stall holds, taken-branch and jump redirects, and flush bubbles from the hazard/branch logic downstream.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, width of PC and instruction-memory address.
NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0) inserted on flush.

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold PC and IF/ID contents
branch_taken  input  1  EX-stage resolved taken branch
branch_target  input  ADDR_W  branch destination
jump  input  1  ID-stage decoded j/jal
jump_target  input  ADDR_W  jump destination
imem_addr  output  ADDR_W  address to instruction_mem (= current PC)
imem_instr  input  32  instruction_mem read data for imem_addr
ifid_instr  output  32  IF/ID registered instruction
ifid_pc_plus4  output  ADDR_W  IF/ID registered PC+4
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)
misalign_err  output  1  sticky: a redirect target had addr[1:0] != 0

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, misalign_err=0. The first fetch happens on the first rising edge after rst_n deasserts.
- imem_addr = pc continuously. instruction_mem is read combinationally: imem_instr is valid for imem_addr within the same cycle.
- Fetch latency: the instruction at PC X appears on ifid_instr one edge after pc=X, with ifid_pc_plus4=X+4.
- Next-PC priority, highest first: branch_taken, then jump, then stall, then sequential.
  - branch_taken=1: pc<=branch_target; IF/ID<=bubble (NOP_INSTR, valid=0). This overrides a simultaneous stall and jump.
  - jump=1, no branch: pc<=jump_target; IF/ID<=bubble, because the instruction fetched this cycle is the jump's wrong-path successor. This overrides stall.
  - stall=1, no redirect: pc and IF/ID all hold their values.
  - Otherwise: pc<=pc+4 (mod 2^ADDR_W, wraps 0xFFFF_FFFC -> 0x0000_0000); IF/ID<={imem_instr, pc+4, valid=1}.
- Redirect targets are taken as given; the low 2 bits are not masked. If a redirect is accepted with target[1:0]!=0, misalign_err<=1. It stays 1 until reset.
- No internal FSM beyond the PC/IF/ID registers. The stage is always fetching. Bubbles have valid=0 and must not be counted as retired instructions.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Decomposition:
- Shared package mips_pkg: ADDR_W, NOP_INSTR, INSTR_W=32, RESET_PC default.
- One sub-module: pc_next_sel, a combinational next-PC/flush-select implementing the priority above. It outputs pc_next, load_ifid and flush_ifid. if_stage holds only registers plus this instance.

Test Plan:
- Reset then run 3 cycles, with imem returning 0x2001_0005, 0x2002_0007, 0x0022_1820 -> imem_addr 0,4,8,12; ifid_pc_plus4 4,8,12; ifid_valid=1 from the first edge.
- stall=1 for 2 cycles at pc=8 -> imem_addr stays 8 and IF/ID is unchanged; after release pc goes to 12 and ifid_pc_plus4=12.
- branch_taken=1, branch_target=0x40 at pc=0x10 -> next cycle imem_addr=0x40, ifid_valid=0, ifid_instr=0; the cycle after that shows ifid_pc_plus4=0x44, valid=1.
- branch_taken=1 (target 0x80) with jump=1 (target 0x100) and stall=1 in the same cycle -> pc=0x80 and a bubble is inserted.
- jump_target=0x102 -> pc=0x102 and misalign_err=1; it stays 1 through later fetches and clears only on rst_n=0.
- Assert rst_n=0 between edges while pc=0x24 -> pc=0, ifid_valid=0 and misalign_err=0 immediately, without waiting for a clock edge.
